// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_e;

    // Width of a counter that must reach max(a,b,c)-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, async reset to 0.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, qualifies its lock and releases a clean system reset;
// retries on lock timeout and latches failure after MAX_RETRIES attempts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned LOCK_STABLE     = 1024,
    parameter int unsigned MAX_RETRIES     = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fail,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

    localparam int unsigned CNT_W   = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic               locked_s;
    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               pll_rst_nxt, sys_rst_nxt, ready_nxt, fail_nxt, lock_lost_nxt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next state, retry count and output values decoded from the next state.
    always_comb begin
        state_nxt     = state;
        retry_nxt     = retry_cnt;
        lock_lost_nxt = 1'b0;

        case (state)
            HOLD: begin
                if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_cnt + RETRY_W'(1);
                    state_nxt = (retry_nxt == RETRY_LIMIT) ? FAIL : HOLD;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt     = HOLD;
                    lock_lost_nxt = 1'b1;
                end
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase

        pll_rst_nxt = (state_nxt == HOLD) || (state_nxt == FAIL);
        sys_rst_nxt = (state_nxt != RUN);
        ready_nxt   = (state_nxt == RUN);
        fail_nxt    = (state_nxt == FAIL);
    end

    // State, counters and registered outputs all move on the same edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= HOLD;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= pll_rst_nxt;
            sys_rst   <= sys_rst_nxt;
            ready     <= ready_nxt;
            fail      <= fail_nxt;
            lock_lost <= lock_lost_nxt;
            if (state_nxt != state)  cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: per-cycle reference model plus hand-computed timing checks.
module tb_pll_lock_supervisor;

    localparam int RST_HOLD = 4;
    localparam int TIMEOUT  = 16;
    localparam int STABLE_N = 8;
    localparam int RETRIES  = 2;
    localparam int SYNC     = 2;

    localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fail, lock_lost;
    logic [1:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // reference model: phase, cycles spent in phase, timeouts, and raw lock samples in flight
    int m_phase   = PH_HOLD;
    int m_age     = 0;
    int m_retries = 0;
    bit m_lost    = 1'b0;
    bit m_samples[$];

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES (RST_HOLD),
        .LOCK_TIMEOUT    (TIMEOUT),
        .LOCK_STABLE     (STABLE_N),
        .MAX_RETRIES     (RETRIES),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic enter(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_reset();
        enter(PH_HOLD);
        m_retries = 0;
        m_lost    = 1'b0;
        m_samples.delete();
        for (int i = 0; i < SYNC; i++) m_samples.push_back(1'b0);
    endtask

    // The supervisor sees pll_locked as sampled SYNC edges earlier.
    task automatic model_step();
        bit seen;
        seen   = m_samples[0];
        m_lost = 1'b0;
        case (m_phase)
            PH_HOLD: begin
                m_age++;
                if (m_age == RST_HOLD) enter(PH_WAIT);
            end
            PH_WAIT: begin
                if (seen) enter(PH_STABLE);
                else begin
                    m_age++;
                    if (m_age == TIMEOUT) begin
                        m_retries++;
                        enter((m_retries == RETRIES) ? PH_FAIL : PH_HOLD);
                    end
                end
            end
            PH_STABLE: begin
                if (!seen) enter(PH_WAIT);
                else begin
                    m_age++;
                    if (m_age == STABLE_N) begin
                        enter(PH_RUN);
                        m_retries = 0;
                    end
                end
            end
            PH_RUN: begin
                if (!seen) begin
                    enter(PH_HOLD);
                    m_lost = 1'b1;
                end
            end
            default: ;
        endcase
        void'(m_samples.pop_front());
        m_samples.push_back(pll_locked);
    endtask

    function automatic logic [6:0] model_outputs();
        return {(m_phase == PH_HOLD) || (m_phase == PH_FAIL),
                m_phase != PH_RUN,
                m_phase == PH_RUN,
                m_phase == PH_FAIL,
                m_lost,
                2'(m_retries)};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge refclk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // per-cycle comparison of every output against the model
    initial begin
        forever begin
            logic [6:0] got, exp;
            @(negedge refclk);
            cycle++;
            got = {pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt};
            exp = model_outputs();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL cycle %0d {pll_rst,sys_rst,ready,fail,lock_lost,retry_cnt}: got %b, expected %b",
                         cycle, got, exp);
            end
        end
    end

    function automatic bit sig(input int which);
        case (which)
            0:       return pll_rst;
            1:       return sys_rst;
            2:       return ready;
            3:       return fail;
            default: return lock_lost;
        endcase
    endfunction

    // Negedges until an output reaches a value, bounded by limit.
    task automatic count_until(input int which, input bit val, input int limit, output int n);
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while ((sig(which) != val) && (n < limit));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pll_rst"},   int'(pll_rst),   1);
        chk({tag, " sys_rst"},   int'(sys_rst),   1);
        chk({tag, " ready"},     int'(ready),     0);
        chk({tag, " fail"},      int'(fail),      0);
        chk({tag, " lock_lost"}, int'(lock_lost), 0);
        chk({tag, " retry_cnt"}, int'(retry_cnt), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge refclk);
        chk_reset_vals("por");

        // power-up: lock arrives right at WAIT_LOCK entry
        rst = 1'b0;
        count_until(0, 1'b0, 50, n);
        chk("hold length", n, 4);
        pll_locked = 1'b1;
        count_until(1, 1'b0, 50, n);
        chk("lock latency", n, 11);
        chk("run ready", int'(ready), 1);
        chk("run retry_cnt", int'(retry_cnt), 0);
        repeat (5) @(negedge refclk);

        // loss of lock in RUN
        pll_locked = 1'b0;
        count_until(4, 1'b1, 20, n);
        chk("lock_lost delay", n, 3);
        chk("lost sys_rst", int'(sys_rst), 1);
        chk("lost ready", int'(ready), 0);
        chk("lost pll_rst", int'(pll_rst), 1);
        @(negedge refclk);
        chk("lost pulse width", int'(lock_lost), 0);
        count_until(0, 1'b0, 20, n);
        chk("re-hold length", n, 3);

        // one timeout, then a retry pulse
        count_until(0, 1'b1, 40, n);
        chk("timeout length", n, 16);
        chk("retry_cnt after timeout", int'(retry_cnt), 1);
        count_until(0, 1'b0, 20, n);
        chk("retry hold length", n, 4);

        // lock drops partway through STABLE, then returns
        pll_locked = 1'b1;
        repeat (7) @(negedge refclk);
        pll_locked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge refclk);
            chk("stable drop sys_rst", int'(sys_rst), 1);
            chk("stable drop retry_cnt", int'(retry_cnt), 1);
        end
        pll_locked = 1'b1;
        count_until(1, 1'b0, 50, n);
        chk("relock latency", n, 11);
        chk("retry_cnt cleared in run", int'(retry_cnt), 0);
        repeat (3) @(negedge refclk);

        // permanent loss: two timeouts lead to FAIL
        pll_locked = 1'b0;
        count_until(3, 1'b1, 200, n);
        chk("fail delay", n, 43);
        chk("fail retry_cnt", int'(retry_cnt), 2);
        chk("fail pll_rst", int'(pll_rst), 1);
        chk("fail sys_rst", int'(sys_rst), 1);
        pll_locked = 1'b1;
        repeat (1000) @(negedge refclk);
        chk("fail sticky", int'(fail), 1);
        chk("fail ready", int'(ready), 0);

        // asynchronous reset out of FAIL
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst in fail");
        @(negedge refclk);
        rst = 1'b0;
        count_until(0, 1'b0, 50, n);
        chk("restart hold length", n, 4);

        // asynchronous reset in the middle of STABLE
        repeat (4) @(negedge refclk);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst in stable");
        @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        rst = 1'b0;

        // lock seen on the exact timeout cycle
        count_until(0, 1'b0, 50, n);
        chk("edge hold length", n, 4);
        repeat (13) @(negedge refclk);
        pll_locked = 1'b1;
        count_until(1, 1'b0, 60, n);
        chk("edge lock latency", n, 11);
        chk("edge retry_cnt", int'(retry_cnt), 0);
        repeat (3) @(negedge refclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
